// File: rtl/eco32_core_ifu_icm_ctl_pkg.sv
// ECO32 IFU instruction-cache miss control: shared constants and types.
// Entry count, pointer width and line-address range used across the IFU.
package eco32_core_ifu_icm_ctl_pkg;
    localparam int ICM_ENTRIES = 16;
    localparam int ICM_PTR_W   = 4;
    localparam int ICM_CNT_W   = 5;
    localparam int VA_HI       = 31;
    localparam int VA_LO       = 6;

    typedef logic [ICM_PTR_W-1:0]   icm_ptr_t;
    typedef logic [ICM_ENTRIES-1:0] icm_vec_t;
    typedef logic [ICM_CNT_W-1:0]   icm_cnt_t;
    typedef logic [VA_HI:VA_LO]     icm_va_t;
endpackage

// File: rtl/eco32_core_ifu_icm_fifo.sv
// ECO32 IFU miss pointer FIFO, 16 x 4 bits.
// Holds allocated entry ids in issue order until memory accepts them.
module eco32_core_ifu_icm_fifo
    import eco32_core_ifu_icm_ctl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  icm_ptr_t push_ptr,
    input  logic     pop,
    output logic     empty,
    output icm_ptr_t head
);
    logic [ICM_PTR_W:0] wr_q;
    logic [ICM_PTR_W:0] rd_q;
    icm_ptr_t           mem_q [ICM_ENTRIES];

    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[ICM_PTR_W-1:0]];

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop && !empty)
                rd_q <= rd_q + 1'b1;
        end
    end

    // Storage is not reset; only slots between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[ICM_PTR_W-1:0]] <= push_ptr;
    end
endmodule

// File: rtl/eco32_core_ifu_icm_ctl.sv
// ECO32 IFU instruction-cache miss controller.
// Allocates miss entries, issues refills in order, tracks flush cancels.
module eco32_core_ifu_icm_ctl
    import eco32_core_ifu_icm_ctl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_stb,
    input  logic [VA_HI:VA_LO]  miss_v_addr,
    input  logic [3:0]          miss_asid,
    input  logic                miss_wid,
    input  logic                miss_tid,
    input  logic                miss_pf,
    output logic                miss_ack,
    output logic                icm_full,
    output logic [4:0]          icm_cnt,
    output logic                tab_wr_stb,
    output logic [3:0]          tab_wr_ptr,
    output logic [VA_HI:VA_LO]  tab_wr_v_addr,
    output logic [3:0]          tab_wr_asid,
    output logic                tab_wr_wid,
    output logic                tab_wr_tag,
    output logic                tab_wr_tid,
    output logic [3:0]          tab_rd_a_ptr,
    output logic                mem_req,
    output logic [3:0]          mem_ptr,
    input  logic                mem_ack,
    input  logic                rsp_stb,
    input  logic [3:0]          rsp_ptr,
    input  logic                rsp_last,
    output logic [3:0]          tab_rd_b_ptr,
    output logic                rsp_drop,
    input  logic                flush_stb,
    input  logic                flush_tid,
    output logic                icm_err
);
    icm_vec_t valid_q, valid_n;
    icm_vec_t cancel_q, cancel_n;
    icm_vec_t tid_q, tid_n;
    icm_cnt_t cnt_q;
    logic     err_q;
    icm_ptr_t alloc_ptr;
    icm_ptr_t head;
    logic     fifo_empty;
    logic     alloc;
    logic     rel;
    logic     bad_rsp;

    assign icm_full = &valid_q;
    assign alloc    = miss_stb & ~icm_full;
    assign rel      = rsp_stb & rsp_last & valid_q[rsp_ptr];
    assign bad_rsp  = rsp_stb & ~valid_q[rsp_ptr];

    assign miss_ack      = alloc;
    assign tab_wr_stb    = alloc;
    assign tab_wr_ptr    = alloc_ptr;
    assign tab_wr_v_addr = miss_v_addr;
    assign tab_wr_asid   = miss_asid;
    assign tab_wr_wid    = miss_wid;
    assign tab_wr_tag    = miss_pf;
    assign tab_wr_tid    = miss_tid;

    assign mem_req      = ~fifo_empty;
    assign mem_ptr      = head;
    assign tab_rd_a_ptr = head;
    assign tab_rd_b_ptr = rsp_ptr;
    assign rsp_drop     = cancel_q[rsp_ptr];
    assign icm_cnt      = cnt_q;
    assign icm_err      = err_q;

    // Lowest-index free entry from the registered valid vector.
    always_comb begin
        alloc_ptr = '0;
        for (int i = ICM_ENTRIES - 1; i >= 0; i--)
            if (!valid_q[i])
                alloc_ptr = icm_ptr_t'(i);
    end

    // Next entry state: flush marks, then allocate, then release wins.
    always_comb begin
        valid_n  = valid_q;
        cancel_n = cancel_q;
        tid_n    = tid_q;
        if (flush_stb) begin
            for (int i = 0; i < ICM_ENTRIES; i++)
                if (valid_q[i] && (tid_q[i] == flush_tid))
                    cancel_n[i] = 1'b1;
        end
        if (alloc) begin
            valid_n[alloc_ptr]  = 1'b1;
            cancel_n[alloc_ptr] = 1'b0;
            tid_n[alloc_ptr]    = miss_tid;
        end
        if (rel) begin
            valid_n[rsp_ptr]  = 1'b0;
            cancel_n[rsp_ptr] = 1'b0;
        end
    end

    // Entry vectors, occupancy count and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            cancel_q <= '0;
            tid_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_n;
            cancel_q <= cancel_n;
            tid_q    <= tid_n;
            case ({alloc, rel})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (bad_rsp)
                err_q <= 1'b1;
        end
    end

    eco32_core_ifu_icm_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (alloc),
        .push_ptr (alloc_ptr),
        .pop      (mem_ack),
        .empty    (fifo_empty),
        .head     (head)
    );
endmodule

// File: tb/tb_eco32_core_ifu_icm_ctl.sv
// Directed bench for the IFU miss controller.
// Each task drives one scenario and checks against hand-derived values.
module tb_eco32_core_ifu_icm_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_stb = 1'b0;
    logic [31:6] miss_v_addr = '0;
    logic [3:0]  miss_asid = '0;
    logic        miss_wid = 1'b0;
    logic        miss_tid = 1'b0;
    logic        miss_pf = 1'b0;
    logic        miss_ack;
    logic        icm_full;
    logic [4:0]  icm_cnt;
    logic        tab_wr_stb;
    logic [3:0]  tab_wr_ptr;
    logic [31:6] tab_wr_v_addr;
    logic [3:0]  tab_wr_asid;
    logic        tab_wr_wid;
    logic        tab_wr_tag;
    logic        tab_wr_tid;
    logic [3:0]  tab_rd_a_ptr;
    logic        mem_req;
    logic [3:0]  mem_ptr;
    logic        mem_ack = 1'b0;
    logic        rsp_stb = 1'b0;
    logic [3:0]  rsp_ptr = '0;
    logic        rsp_last = 1'b0;
    logic [3:0]  tab_rd_b_ptr;
    logic        rsp_drop;
    logic        flush_stb = 1'b0;
    logic        flush_tid = 1'b0;
    logic        icm_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eco32_core_ifu_icm_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .miss_stb      (miss_stb),
        .miss_v_addr   (miss_v_addr),
        .miss_asid     (miss_asid),
        .miss_wid      (miss_wid),
        .miss_tid      (miss_tid),
        .miss_pf       (miss_pf),
        .miss_ack      (miss_ack),
        .icm_full      (icm_full),
        .icm_cnt       (icm_cnt),
        .tab_wr_stb    (tab_wr_stb),
        .tab_wr_ptr    (tab_wr_ptr),
        .tab_wr_v_addr (tab_wr_v_addr),
        .tab_wr_asid   (tab_wr_asid),
        .tab_wr_wid    (tab_wr_wid),
        .tab_wr_tag    (tab_wr_tag),
        .tab_wr_tid    (tab_wr_tid),
        .tab_rd_a_ptr  (tab_rd_a_ptr),
        .mem_req       (mem_req),
        .mem_ptr       (mem_ptr),
        .mem_ack       (mem_ack),
        .rsp_stb       (rsp_stb),
        .rsp_ptr       (rsp_ptr),
        .rsp_last      (rsp_last),
        .tab_rd_b_ptr  (tab_rd_b_ptr),
        .rsp_drop      (rsp_drop),
        .flush_stb     (flush_stb),
        .flush_tid     (flush_tid),
        .icm_err       (icm_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input logic tid);
        miss_stb = 1'b1;
        miss_tid = tid;
        tick();
        miss_stb = 1'b0;
    endtask

    task automatic do_rel(input logic [3:0] p);
        rsp_stb  = 1'b1;
        rsp_last = 1'b1;
        rsp_ptr  = p;
        tick();
        rsp_stb  = 1'b0;
        rsp_last = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!mem_req)
                break;
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: mem_req=%0b want 0", mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({miss_ack, icm_full, mem_req, tab_wr_stb, rsp_drop, icm_err}
            !== 6'b0 || icm_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_outs: ack/full/req/wr/drop/err=%b cnt=%0d want 0",
                {miss_ack, icm_full, mem_req, tab_wr_stb, rsp_drop, icm_err},
                icm_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_miss();
        miss_stb    = 1'b1;
        miss_v_addr = 26'h4;
        miss_tid    = 1'b0;
        miss_pf     = 1'b1;
        #1;
        checks++;
        if (miss_ack !== 1'b1 || tab_wr_stb !== 1'b1 || tab_wr_ptr !== 4'd0
            || tab_wr_v_addr !== 26'h4 || tab_wr_tag !== 1'b1) begin
            errors++;
            $display("FAIL first_alloc: ack=%0b wr=%0b ptr=%0d va=%0h tag=%0b want 1 1 0 4 1",
                miss_ack, tab_wr_stb, tab_wr_ptr, tab_wr_v_addr, tab_wr_tag);
        end
        tick();
        miss_stb = 1'b0;
        miss_pf  = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_ptr !== 4'd0 || icm_cnt !== 5'd1
            || tab_rd_a_ptr !== 4'd0) begin
            errors++;
            $display("FAIL first_issue: req=%0b ptr=%0d cnt=%0d want 1 0 1",
                mem_req, mem_ptr, icm_cnt);
        end
        drain();
        do_rel(4'd0);
        checks++;
        if (icm_cnt !== 5'd0) begin
            errors++;
            $display("FAIL first_release: cnt=%0d want 0", icm_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            miss_stb = 1'b1;
            miss_tid = 1'(i);
            #1;
            checks++;
            if (miss_ack !== 1'b1 || tab_wr_ptr !== 4'(i)) begin
                errors++;
                $display("FAIL b2b_alloc%0d: ack=%0b ptr=%0d want 1 %0d",
                    i, miss_ack, tab_wr_ptr, i);
            end
            tick();
        end
        miss_stb = 1'b1;
        #1;
        checks++;
        if (icm_full !== 1'b1 || icm_cnt !== 5'd16 || miss_ack !== 1'b0
            || tab_wr_stb !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: full=%0b cnt=%0d ack=%0b wr=%0b want 1 16 0 0",
                icm_full, icm_cnt, miss_ack, tab_wr_stb);
        end
        miss_stb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_ptr !== 4'(i)) begin
                errors++;
                $display("FAIL b2b_issue%0d: req=%0b ptr=%0d want 1 %0d",
                    i, mem_req, mem_ptr, i);
            end
            mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: req=%0b want 0", mem_req);
        end
    endtask

    task automatic test_full_release();
        miss_stb = 1'b1;
        miss_tid = 1'b1;
        rsp_stb  = 1'b1;
        rsp_last = 1'b1;
        rsp_ptr  = 4'd5;
        #1;
        checks++;
        if (miss_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_same_cycle: ack=%0b want 0", miss_ack);
        end
        tick();
        rsp_stb  = 1'b0;
        rsp_last = 1'b0;
        #1;
        checks++;
        if (miss_ack !== 1'b1 || tab_wr_ptr !== 4'd5 || icm_cnt !== 5'd15) begin
            errors++;
            $display("FAIL full_next_cycle: ack=%0b ptr=%0d cnt=%0d want 1 5 15",
                miss_ack, tab_wr_ptr, icm_cnt);
        end
        tick();
        miss_stb = 1'b0;
        checks++;
        if (icm_cnt !== 5'd16 || icm_full !== 1'b1) begin
            errors++;
            $display("FAIL full_refill: cnt=%0d full=%0b want 16 1",
                icm_cnt, icm_full);
        end
        for (int i = 0; i < 16; i++)
            do_rel(4'(i));
        checks++;
        if (icm_cnt !== 5'd0 || icm_full !== 1'b0 || icm_err !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: cnt=%0d full=%0b err=%0b want 0 0 0",
                icm_cnt, icm_full, icm_err);
        end
        drain();
    endtask

    task automatic test_flush();
        do_miss(1'b0);
        do_miss(1'b0);
        do_miss(1'b1);
        do_miss(1'b0);
        flush_stb = 1'b1;
        flush_tid = 1'b1;
        miss_stb  = 1'b1;
        miss_tid  = 1'b1;
        tick();
        flush_stb = 1'b0;
        miss_stb  = 1'b0;
        rsp_stb   = 1'b1;
        rsp_last  = 1'b0;
        rsp_ptr   = 4'd2;
        #1;
        checks++;
        if (rsp_drop !== 1'b1 || tab_rd_b_ptr !== 4'd2) begin
            errors++;
            $display("FAIL flush_drop2: drop=%0b bptr=%0d want 1 2",
                rsp_drop, tab_rd_b_ptr);
        end
        rsp_ptr = 4'd3;
        #1;
        checks++;
        if (rsp_drop !== 1'b0) begin
            errors++;
            $display("FAIL flush_keep3: drop=%0b want 0", rsp_drop);
        end
        rsp_ptr = 4'd4;
        #1;
        checks++;
        if (rsp_drop !== 1'b0) begin
            errors++;
            $display("FAIL flush_same_alloc: drop=%0b want 0", rsp_drop);
        end
        tick();
        rsp_stb = 1'b0;
        checks++;
        if (icm_cnt !== 5'd5) begin
            errors++;
            $display("FAIL flush_nonlast: cnt=%0d want 5", icm_cnt);
        end
        flush_stb = 1'b1;
        flush_tid = 1'b0;
        do_rel(4'd3);
        flush_stb = 1'b0;
        rsp_ptr   = 4'd3;
        #1;
        checks++;
        if (rsp_drop !== 1'b0 || icm_cnt !== 5'd4) begin
            errors++;
            $display("FAIL flush_rel_wins: drop=%0b cnt=%0d want 0 4",
                rsp_drop, icm_cnt);
        end
        rsp_ptr = 4'd0;
        #1;
        checks++;
        if (rsp_drop !== 1'b1) begin
            errors++;
            $display("FAIL flush_tid0: drop=%0b want 1", rsp_drop);
        end
        miss_stb = 1'b1;
        #1;
        checks++;
        if (tab_wr_ptr !== 4'd3) begin
            errors++;
            $display("FAIL flush_realloc: ptr=%0d want 3", tab_wr_ptr);
        end
        miss_stb = 1'b0;
        do_rel(4'd0);
        do_rel(4'd1);
        do_rel(4'd2);
        do_rel(4'd4);
        checks++;
        if (icm_cnt !== 5'd0 || icm_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_cleanup: cnt=%0d err=%0b want 0 0",
                icm_cnt, icm_err);
        end
        drain();
    endtask

    task automatic test_mem_hold();
        do_miss(1'b0);
        do_miss(1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_ptr !== 4'd0) begin
                errors++;
                $display("FAIL hold_cyc%0d: req=%0b ptr=%0d want 1 0",
                    i, mem_req, mem_ptr);
            end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_ptr !== 4'd1) begin
            errors++;
            $display("FAIL hold_next_head: req=%0b ptr=%0d want 1 1",
                mem_req, mem_ptr);
        end
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        do_miss(1'b0);
        checks++;
        if (mem_req !== 1'b1 || mem_ptr !== 4'd2) begin
            errors++;
            $display("FAIL hold_idle_ack: req=%0b ptr=%0d want 1 2",
                mem_req, mem_ptr);
        end
        do_rel(4'd0);
        do_rel(4'd1);
        do_rel(4'd2);
        drain();
    endtask

    task automatic test_err();
        do_miss(1'b0);
        rsp_stb  = 1'b1;
        rsp_last = 1'b1;
        rsp_ptr  = 4'd9;
        tick();
        rsp_stb  = 1'b0;
        rsp_last = 1'b0;
        checks++;
        if (icm_err !== 1'b1 || icm_cnt !== 5'd1) begin
            errors++;
            $display("FAIL err_set: err=%0b cnt=%0d want 1 1", icm_err, icm_cnt);
        end
        tick();
        checks++;
        if (icm_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%0b want 1", icm_err);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (icm_cnt !== 5'd0 || icm_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: cnt=%0d err=%0b req=%0b want 0 0 0",
                icm_cnt, icm_err, mem_req);
        end
        rst = 1'b0;
        do_rel(4'd0);
        checks++;
        if (icm_err !== 1'b1 || icm_cnt !== 5'd0) begin
            errors++;
            $display("FAIL rst_late_rsp: err=%0b cnt=%0d want 1 0",
                icm_err, icm_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_back_to_back();
        test_full_release();
        test_flush();
        test_mem_hold();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eco32_core_ifu_icm_ctl.md
ECO32_CORE_IFU_ICM_CTL -- requirements
Module: eco32_core_ifu_icm_ctl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 miss_stb  in  1  instruction-cache miss request valid.
REQ-004 miss_v_addr  in  [31:6]  missing line virtual address.
REQ-005 miss_asid  in  4  address-space id.
REQ-006 miss_wid  in  1  way id to refill.
REQ-007 miss_tid  in  1  thread id.
REQ-008 miss_pf  in  1  request is a prefetch; written as table tag bit.
REQ-009 miss_ack  out  1  miss accepted this cycle (combinational: miss_stb & ~full).
REQ-010 icm_full  out  1  all 16 entries valid.
REQ-011 icm_cnt  out  5  number of valid entries, 0..16.
REQ-012 tab_wr_stb, tab_wr_ptr[3:0], tab_wr_v_addr[31:6], tab_wr_asid[3:0], tab_wr_wid, tab_wr_tag, tab_wr_tid  out  table write port; combinational from the miss inputs and allocated pointer.
REQ-013 tab_rd_a_ptr  out  4  table read port A pointer = issue FIFO head.
REQ-014 mem_req  out  1  refill request to memory pending; mem_ptr  out  4  entry being requested (= tab_rd_a_ptr).
REQ-015 mem_ack  in  1  memory accepted the current mem_req.
REQ-016 rsp_stb  in  1  refill data beat; rsp_ptr  in  4  entry id; rsp_last  in  1  final beat.
REQ-017 tab_rd_b_ptr  out  4  table read port B pointer, combinational = rsp_ptr.
REQ-018 rsp_drop  out  1  combinational: current rsp_ptr entry is cancelled; refill data is discarded.
REQ-019 flush_stb  in  1, flush_tid  in  1  cancel all outstanding entries of a thread.
REQ-020 icm_err  out  1  sticky: response received for an invalid entry.

Function
REQ-021 Per entry the block SHALL hold valid, cancel and tid bits (16 each).
REQ-022 Allocation SHALL select the lowest-index entry whose valid bit is 0 in the registered state.
REQ-023 When miss_stb=1 and icm_full=0: miss_ack=1, tab_wr_stb=1, tab_wr_ptr=allocated index; the entry's valid bit is set, its cancel bit is cleared and its tid is stored at the next edge.
REQ-024 When icm_full=1: miss_ack=0, tab_wr_stb=0, and the request is held by the requester.
REQ-025 An accepted pointer SHALL be pushed into a 16-deep pointer FIFO at the same edge; the FIFO cannot overflow.
REQ-026 mem_req SHALL equal FIFO non-empty; the head SHALL be held stable until mem_ack; mem_ack with mem_req=1 pops the head at the edge; mem_ack with mem_req=0 is ignored.
REQ-027 Latency: a miss accepted in cycle N with an empty FIFO SHALL produce mem_req=1 in cycle N+1.
REQ-028 On rsp_stb & rsp_last with valid[rsp_ptr]=1, the entry's valid and cancel bits SHALL clear at the edge; a freed entry becomes allocatable in the next cycle, never in the same cycle.
REQ-029 On rsp_stb with valid[rsp_ptr]=0, state SHALL be unchanged and icm_err set.
REQ-030 flush_stb SHALL set cancel on every valid entry with tid==flush_tid; entries are not freed until their last response arrives.
REQ-031 A miss accepted in the same cycle as flush_stb SHALL NOT be cancelled.
REQ-032 A flush coinciding with the last response for the same entry: the release wins, and the entry ends with valid=0 and cancel=0.
REQ-033 icm_cnt SHALL be updated at each edge by +1 (alloc), -1 (release), or 0 (both or neither).

Reset
REQ-034 rst SHALL asynchronously clear valid, cancel, tid, the FIFO pointers, icm_cnt and icm_err; resulting outputs: miss_ack=0, icm_full=0, mem_req=0, tab_wr_stb=0, rsp_drop=0.
REQ-035 Reset mid-operation SHALL abandon all entries; late responses after reset set icm_err.
REQ-036 Table contents are not reset; validity comes solely from this block.

Structure
REQ-037 The entry count (16), pointer width (4) and address range [31:6] SHALL be constants in the shared IFU package.
REQ-038 The pointer FIFO SHALL be one sub-module, eco32_core_ifu_icm_fifo (16x4, distributed storage).
REQ-039 The priority encoder and the valid/cancel vectors SHALL remain in this module.

Verification
REQ-040 After reset, miss_stb with v_addr=0x0000100: miss_ack=1, tab_wr_ptr=0; next cycle mem_req=1, mem_ptr=0, icm_cnt=1.
REQ-041 16 back-to-back misses with no responses: ptrs 0..15, then icm_full=1; the 17th miss gets miss_ack=0.
REQ-042 With the table full, rsp_last for ptr 5 in cycle N, miss in cycle N: no ack in N; ack with ptr 5 in N+1.
REQ-043 Entries 2 (tid 1) and 3 (tid 0) outstanding, flush_tid=1: a response for ptr 2 gives rsp_drop=1, and for ptr 3 gives rsp_drop=0.
REQ-044 mem_ack withheld for 5 cycles: mem_ptr is stable; on ack the next head appears in the following cycle.
REQ-045 rsp_stb for unallocated ptr 9: icm_err=1, icm_cnt unchanged.
